// File: rtl/holly_bus_decoder_pkg.sv
// Shared definitions for the HOLLY data-bus decoder: FSM states, the standard
// HOLLY physical memory map, and the default 8-region decode table.
package holly_bus_pkg;

    localparam int HOLLY_ADDR_W = 29;
    localparam int HOLLY_NUM_DEF_REGIONS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } holly_state_e;

    typedef logic [HOLLY_ADDR_W-1:0] holly_addr_t;

    localparam holly_addr_t FLASH_BASE    = 29'h0020_0000;
    localparam holly_addr_t FLASH_LAST    = 29'h0021_FFFF;
    localparam holly_addr_t SYSTEM_BASE   = 29'h005F_6800;
    localparam holly_addr_t SYSTEM_LAST   = 29'h005F_69FF;
    localparam holly_addr_t MAPLE_BASE    = 29'h005F_6C00;
    localparam holly_addr_t MAPLE_LAST    = 29'h005F_6CFF;
    localparam holly_addr_t GDROM_BASE    = 29'h005F_7000;
    localparam holly_addr_t GDROM_LAST    = 29'h005F_70FF;
    localparam holly_addr_t G1_BASE       = 29'h005F_7400;
    localparam holly_addr_t G1_LAST       = 29'h005F_74FF;
    localparam holly_addr_t G2_BASE       = 29'h005F_7800;
    localparam holly_addr_t G2_LAST       = 29'h005F_78FF;
    localparam holly_addr_t PVR_REG_BASE  = 29'h005F_7C00;
    localparam holly_addr_t PVR_REG_LAST  = 29'h005F_7CFF;
    localparam holly_addr_t TA_REG_BASE   = 29'h005F_8000;
    localparam holly_addr_t TA_REG_LAST   = 29'h005F_9FFF;
    localparam holly_addr_t MODEM_BASE    = 29'h0060_0000;
    localparam holly_addr_t MODEM_LAST    = 29'h0060_07FF;
    localparam holly_addr_t AICA_REG_BASE = 29'h0070_0000;
    localparam holly_addr_t AICA_REG_LAST = 29'h0070_7FFF;
    localparam holly_addr_t AICA_RTC_BASE = 29'h0071_0000;
    localparam holly_addr_t AICA_RTC_LAST = 29'h0071_000B;
    localparam holly_addr_t AICA_RAM_BASE = 29'h0080_0000;
    localparam holly_addr_t AICA_RAM_LAST = 29'h009F_FFFF;
    localparam holly_addr_t G2_EXT_BASE   = 29'h0100_0000;
    localparam holly_addr_t G2_EXT_LAST   = 29'h01FF_FFFF;
    localparam holly_addr_t VRAM64_BASE   = 29'h0400_0000;
    localparam holly_addr_t VRAM64_LAST   = 29'h047F_FFFF;
    localparam holly_addr_t VRAM32_BASE   = 29'h0500_0000;
    localparam holly_addr_t VRAM32_LAST   = 29'h057F_FFFF;
    localparam holly_addr_t VRAM64_M_BASE = 29'h0600_0000;
    localparam holly_addr_t VRAM64_M_LAST = 29'h067F_FFFF;
    localparam holly_addr_t VRAM32_M_BASE = 29'h0700_0000;
    localparam holly_addr_t VRAM32_M_LAST = 29'h077F_FFFF;
    localparam holly_addr_t SDRAM_BASE    = 29'h0C00_0000;
    localparam holly_addr_t SDRAM_LAST    = 29'h0FFF_FFFF;
    localparam holly_addr_t TA_FIFO_BASE  = 29'h1000_0000;
    localparam holly_addr_t TA_FIFO_LAST  = 29'h107F_FFFF;
    localparam holly_addr_t TA_YUV_BASE   = 29'h1080_0000;
    localparam holly_addr_t TA_YUV_LAST   = 29'h10FF_FFFF;
    localparam holly_addr_t TA_TEX_BASE   = 29'h1100_0000;
    localparam holly_addr_t TA_TEX_LAST   = 29'h11FF_FFFF;

    // Region i lives in slice i, so the highest region is the leftmost term.
    localparam logic [HOLLY_NUM_DEF_REGIONS*HOLLY_ADDR_W-1:0] HOLLY_DEF_BASE = {
        TA_FIFO_BASE, SDRAM_BASE, AICA_RAM_BASE, AICA_REG_BASE,
        VRAM32_BASE, VRAM64_BASE, TA_REG_BASE, PVR_REG_BASE
    };
    localparam logic [HOLLY_NUM_DEF_REGIONS*HOLLY_ADDR_W-1:0] HOLLY_DEF_LAST = {
        TA_FIFO_LAST, SDRAM_LAST, AICA_RAM_LAST, AICA_REG_LAST,
        VRAM32_LAST, VRAM64_LAST, TA_REG_LAST, PVR_REG_LAST
    };

endpackage

// File: rtl/holly_bus_decoder_if.sv
// Core-side request/response channel of the HOLLY bus decoder.
interface holly_bus_decoder_if #(
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  req_wen;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/holly_bus_decoder_region_match.sv
// Combinational region table lookup: priority one-hot (lowest index wins on
// overlap) plus an any-hit flag.
module holly_region_match #(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_W = 29,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] sel_onehot,
    output logic                   any_hit
);

    // Scanning from the top down lets the lowest matching index overwrite.
    always_comb begin
        sel_onehot = '0;
        any_hit    = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                (addr <= REGION_LAST[i*ADDR_W +: ADDR_W])) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                any_hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/holly_bus_decoder.sv
// Registered HOLLY/SH4 data-bus decoder with per-target ack, timeout and
// unmapped-access errors. Optional error log enabled by HOLLY_BUS_ERRLOG_EN.
module holly_bus_decoder
    import holly_bus_pkg::*;
#(
    parameter int NUM_REGIONS = HOLLY_NUM_DEF_REGIONS,
    parameter int ADDR_W = HOLLY_ADDR_W,
    parameter int DATA_W = 64,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = HOLLY_DEF_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST = HOLLY_DEF_LAST,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = '1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    holly_bus_decoder_if.slave            bus,
    output logic [NUM_REGIONS-1:0]        tgt_sel,
    output logic                          tgt_req,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic                          tgt_wen,
    output logic [DATA_W-1:0]             tgt_wdata,
    output logic [DATA_W/8-1:0]           tgt_wmask,
    input  logic [NUM_REGIONS-1:0]        tgt_ack,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata
`ifdef HOLLY_BUS_ERRLOG_EN
    ,
    input  logic                          err_clr,
    output logic [ADDR_W-1:0]             err_addr,
    output logic                          err_is_timeout,
    output logic [15:0]                   err_count
`endif
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    holly_state_e          state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [7:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;

    logic [NUM_REGIONS-1:0] hit_onehot;
    logic                  any_hit;
    logic                  ack_hit;
    logic [DATA_W-1:0]     sel_rdata;

    // Upper address bits are deliberately ignored so the map mirrors.
    logic unused_addr_hi;
    if (ADDR_W < 32) begin : g_addr_hi
        assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];
    end else begin : g_no_addr_hi
        assign unused_addr_hi = 1'b0;
    end

    holly_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_LAST (REGION_LAST)
    ) u_match (
        .addr       (bus.req_addr[ADDR_W-1:0]),
        .sel_onehot (hit_onehot),
        .any_hit    (any_hit)
    );

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | tgt_rdata[i*DATA_W +: DATA_W];
        end
        ack_hit = |(tgt_ack & sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        count_d = count_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[ADDR_W-1:0];
                    wen_d   = bus.req_wen;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    count_d = '0;
                    if (any_hit) begin
                        state_d = ST_ACCESS;
                        sel_d   = hit_onehot;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = bus.req_wen ? '0 : UNMAPPED_DATA;
                    end
                end
            end
            // An ack in the final allowed cycle still counts as success.
            ST_ACCESS: begin
                if (ack_hit) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = wen_q ? '0 : sel_rdata;
                end else if (count_q == TO_LAST) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = wen_q ? '0 : UNMAPPED_DATA;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_err   = (state_q == ST_RESP) && err_q;
        bus.resp_rdata = rdata_q;
        tgt_req        = (state_q == ST_ACCESS);
        tgt_sel        = sel_q;
        tgt_addr       = addr_q;
        tgt_wen        = wen_q;
        tgt_wdata      = wdata_q;
        tgt_wmask      = wmask_q;
    end

`ifdef HOLLY_BUS_ERRLOG_EN
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_is_timeout_q, err_is_timeout_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              err_event;

    // Errors are logged on the same edge that enters RESP with err set.
    always_comb begin
        err_event = ((state_q == ST_IDLE) && bus.req_valid && !any_hit) ||
                    ((state_q == ST_ACCESS) && !ack_hit && (count_q == TO_LAST));
        err_addr_d       = err_addr_q;
        err_is_timeout_d = err_is_timeout_q;
        err_count_d      = err_count_q;
        if (err_clr) begin
            err_addr_d       = '0;
            err_is_timeout_d = 1'b0;
            err_count_d      = '0;
        end else if (err_event) begin
            err_addr_d       = (state_q == ST_IDLE) ? bus.req_addr[ADDR_W-1:0] : addr_q;
            err_is_timeout_d = (state_q == ST_ACCESS);
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_q       <= '0;
            err_is_timeout_q <= 1'b0;
            err_count_q      <= '0;
        end else begin
            err_addr_q       <= err_addr_d;
            err_is_timeout_q <= err_is_timeout_d;
            err_count_q      <= err_count_d;
        end
    end

    assign err_addr       = err_addr_q;
    assign err_is_timeout = err_is_timeout_q;
    assign err_count      = err_count_q;
`endif

endmodule

// File: tb/tb_holly_bus_decoder.sv
// Directed self-checking bench for holly_bus_decoder; a per-cycle model of the
// request/response timing is compared against the DUT on every falling edge.
module tb_holly_bus_decoder;

    localparam int NR = 8;
    localparam int AW = 29;
    localparam int DW = 64;
    localparam int TO = 4;

    localparam logic [AW-1:0] TB_BASE [NR] = '{
        29'h005F_7C00, 29'h005F_8000, 29'h0040_0000, 29'h0400_0000,
        29'h0070_0000, 29'h0048_0000, 29'h0C00_0000, 29'h1000_0000
    };
    localparam logic [AW-1:0] TB_LAST [NR] = '{
        29'h005F_7CFF, 29'h005F_9FFF, 29'h004F_FFFF, 29'h047F_FFFF,
        29'h0070_7FFF, 29'h0048_FFFF, 29'h0CFF_FFFF, 29'h107F_FFFF
    };
    localparam logic [NR*AW-1:0] BASE_FLAT = {
        TB_BASE[7], TB_BASE[6], TB_BASE[5], TB_BASE[4],
        TB_BASE[3], TB_BASE[2], TB_BASE[1], TB_BASE[0]
    };
    localparam logic [NR*AW-1:0] LAST_FLAT = {
        TB_LAST[7], TB_LAST[6], TB_LAST[5], TB_LAST[4],
        TB_LAST[3], TB_LAST[2], TB_LAST[1], TB_LAST[0]
    };

    logic clock = 1'b0;
    logic reset_n;
    logic [NR-1:0]    tgt_sel;
    logic             tgt_req;
    logic [AW-1:0]    tgt_addr;
    logic             tgt_wen;
    logic [DW-1:0]    tgt_wdata;
    logic [DW/8-1:0]  tgt_wmask;
    logic [NR-1:0]    tgt_ack;
    logic [NR*DW-1:0] tgt_rdata;
`ifdef HOLLY_BUS_ERRLOG_EN
    logic             err_clr;
    logic [AW-1:0]    err_addr;
    logic             err_is_timeout;
    logic [15:0]      err_count;
`endif

    holly_bus_decoder_if #(.DATA_W(DW)) bus ();

    holly_bus_decoder #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .REGION_BASE (BASE_FLAT),
        .REGION_LAST (LAST_FLAT),
        .TIMEOUT     (TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .tgt_sel   (tgt_sel),
        .tgt_req   (tgt_req),
        .tgt_addr  (tgt_addr),
        .tgt_wen   (tgt_wen),
        .tgt_wdata (tgt_wdata),
        .tgt_wmask (tgt_wmask),
        .tgt_ack   (tgt_ack),
        .tgt_rdata (tgt_rdata)
`ifdef HOLLY_BUS_ERRLOG_EN
        ,
        .err_clr        (err_clr),
        .err_addr       (err_addr),
        .err_is_timeout (err_is_timeout),
        .err_count      (err_count)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model of the transaction in flight.
    bit          m_active = 1'b0;
    int          m_accept, m_resp, m_region;
    logic [31:0] m_addr;
    logic        m_wen, m_err;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    int          last_resp_cyc;
    logic [63:0] last_rdata;
    logic        last_err;
    logic [7:0]  last_sel;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_region(input logic [31:0] a);
        logic [AW-1:0] m;
        m = a[AW-1:0];
        for (int i = 0; i < NR; i++) begin
            if (m >= TB_BASE[i] && m <= TB_LAST[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        bit busy, exp_req, exp_resp;
        logic [7:0] exp_sel;
        busy     = m_active && (cyc > m_accept) && (cyc <= m_resp);
        exp_resp = m_active && (cyc == m_resp);
        exp_req  = busy && (m_region >= 0) && (cyc < m_resp);
        exp_sel  = exp_req ? (8'b1 << m_region) : 8'h00;
        check_output("req_ready", 64'(bus.req_ready), 64'(!busy));
        check_output("resp_valid", 64'(bus.resp_valid), 64'(exp_resp));
        check_output("tgt_req", 64'(tgt_req), 64'(exp_req));
        check_output("tgt_sel", 64'(tgt_sel), 64'(exp_sel));
        if (exp_resp) begin
            check_output("resp_rdata", bus.resp_rdata, m_rdata);
            check_output("resp_err", 64'(bus.resp_err), 64'(m_err));
        end
        if (exp_req) begin
            check_output("tgt_addr", 64'(tgt_addr), 64'(m_addr[AW-1:0]));
            check_output("tgt_wen", 64'(tgt_wen), 64'(m_wen));
            check_output("tgt_wdata", tgt_wdata, m_wdata);
            check_output("tgt_wmask", 64'(tgt_wmask), 64'(m_wmask));
        end
        if (bus.resp_valid) begin
            last_resp_cyc = cyc;
            last_rdata    = bus.resp_rdata;
            last_err      = bus.resp_err;
        end
        if (tgt_sel != '0) last_sel = tgt_sel;
    end

    // Drives a request for one cycle and records what the model expects.
    task automatic start_request(input logic [31:0] addr, input logic wen, input logic [63:0] wdata,
                                 input logic [7:0] wmask, input int ack_region, input int ack_k,
                                 input logic [63:0] rdata, output int acc);
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wen   = wen;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        acc           = cyc;
        last_resp_cyc = -1;
        last_sel      = 8'h00;
        m_accept = cyc;
        m_addr   = addr;
        m_wen    = wen;
        m_wdata  = wdata;
        m_wmask  = wmask;
        m_region = model_region(addr);
        if (m_region < 0) begin
            m_resp  = cyc + 1;
            m_err   = 1'b1;
            m_rdata = wen ? 64'h0 : {64{1'b1}};
        end else if (ack_region == m_region && ack_k >= 1 && ack_k <= TO) begin
            m_resp  = cyc + 1 + ack_k;
            m_err   = 1'b0;
            m_rdata = wen ? 64'h0 : rdata;
        end else begin
            m_resp  = cyc + TO + 1;
            m_err   = 1'b1;
            m_rdata = wen ? 64'h0 : {64{1'b1}};
        end
        m_active = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic wen, input logic [63:0] wdata,
                                  input logic [7:0] wmask, input int ack_region, input int ack_k,
                                  input logic [63:0] rdata, output int acc);
        for (int i = 0; i < NR; i++) tgt_rdata[i*DW +: DW] = 64'hBAD0_0000_0000_0000 | 64'(i);
        if (ack_region >= 0) tgt_rdata[ack_region*DW +: DW] = rdata;
        start_request(addr, wen, wdata, wmask, ack_region, ack_k, rdata, acc);
        while (cyc <= m_resp) begin
            tgt_ack = (ack_k >= 1 && cyc == acc + ack_k) ? (8'b1 << ack_region) : 8'h00;
            @(posedge clock); #1;
        end
        tgt_ack = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        reset_n       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wen   = 1'b0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        tgt_ack       = '0;
        tgt_rdata     = '0;
`ifdef HOLLY_BUS_ERRLOG_EN
        err_clr       = 1'b0;
`endif
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_ready", 64'(bus.req_ready), 64'h1);
        check_output("rst_valid", 64'(bus.resp_valid), 64'h0);
        check_output("rst_err", 64'(bus.resp_err), 64'h0);
        check_output("rst_rdata", bus.resp_rdata, 64'h0);
        check_output("rst_tgt_req", 64'(tgt_req), 64'h0);
        check_output("rst_tgt_sel", 64'(tgt_sel), 64'h0);
        check_output("rst_tgt_addr", 64'(tgt_addr), 64'h0);
        check_output("rst_tgt_wen", 64'(tgt_wen), 64'h0);
        check_output("rst_tgt_wdata", tgt_wdata, 64'h0);
        check_output("rst_tgt_wmask", 64'(tgt_wmask), 64'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Mapped read, ack in first access cycle.
        apply_stimulus(32'h005F_7C40, 1'b0, 64'h0, 8'h00, 0, 1, 64'h0000_0000_1234_5678, acc);
        check_output("rd_latency", 64'(last_resp_cyc - acc), 64'd2);
        check_output("rd_sel", 64'(last_sel), 64'h01);
        check_output("rd_data", last_rdata, 64'h0000_0000_1234_5678);
        check_output("rd_err", 64'(last_err), 64'h0);

        // Mirrored write into region 0.
        apply_stimulus(32'hE05F_7C40, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 0, 1, 64'h5555_AAAA_5555_AAAA, acc);
        check_output("wr_latency", 64'(last_resp_cyc - acc), 64'd2);
        check_output("wr_sel", 64'(last_sel), 64'h01);
        check_output("wr_rdata", last_rdata, 64'h0);
        check_output("wr_err", 64'(last_err), 64'h0);
        check_output("wr_tgt_addr", 64'(tgt_addr), 64'h005F_7C40);
        check_output("wr_tgt_wen", 64'(tgt_wen), 64'h1);
        check_output("wr_tgt_wdata", tgt_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check_output("wr_tgt_wmask", 64'(tgt_wmask), 64'h0F);

        // Unmapped read.
        apply_stimulus(32'h0030_0000, 1'b0, 64'h0, 8'h00, -1, 0, 64'h0, acc);
        check_output("um_latency", 64'(last_resp_cyc - acc), 64'd1);
        check_output("um_sel", 64'(last_sel), 64'h00);
        check_output("um_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("um_err", 64'(last_err), 64'h1);
`ifdef HOLLY_BUS_ERRLOG_EN
        check_output("log_count", 64'(err_count), 64'd1);
        check_output("log_addr", 64'(err_addr), 64'h0030_0000);
        check_output("log_is_to", 64'(err_is_timeout), 64'h0);
`endif

        // Timeout with no ack, then ack landing in the final access cycle.
        apply_stimulus(32'h0C00_0100, 1'b0, 64'h0, 8'h00, 6, 0, 64'h0, acc);
        check_output("to_latency", 64'(last_resp_cyc - acc), 64'd5);
        check_output("to_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("to_err", 64'(last_err), 64'h1);
`ifdef HOLLY_BUS_ERRLOG_EN
        check_output("log_count2", 64'(err_count), 64'd2);
        check_output("log_is_to2", 64'(err_is_timeout), 64'h1);
        err_clr = 1'b1;
        @(posedge clock); #1;
        err_clr = 1'b0;
        check_output("log_clr", 64'(err_count), 64'd0);
`endif
        apply_stimulus(32'h0C00_0100, 1'b0, 64'h0, 8'h00, 6, 4, 64'hA5A5_0000_1111_2222, acc);
        check_output("late_ack_latency", 64'(last_resp_cyc - acc), 64'd5);
        check_output("late_ack_rdata", last_rdata, 64'hA5A5_0000_1111_2222);
        check_output("late_ack_err", 64'(last_err), 64'h0);

        // Write timeout returns zero data.
        apply_stimulus(32'h1000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 7, 0, 64'h0, acc);
        check_output("wto_rdata", last_rdata, 64'h0);
        check_output("wto_err", 64'(last_err), 64'h1);

        // Overlap of regions 2 and 5; ack on 5 alone is ignored.
        apply_stimulus(32'h0048_1000, 1'b0, 64'h0, 8'h00, 5, 1, 64'h7777_7777_7777_7777, acc);
        check_output("ovl_sel", 64'(last_sel), 64'h04);
        check_output("ovl_latency", 64'(last_resp_cyc - acc), 64'd5);
        check_output("ovl_err", 64'(last_err), 64'h1);

        // Reset during the second access cycle aborts without a response.
        start_request(32'h005F_7C10, 1'b0, 64'h0, 8'h00, -1, 0, 64'h0, acc);
        @(posedge clock); #1;
        reset_n  = 1'b0;
        m_active = 1'b0;
        #1;
        check_output("abort_tgt_req", 64'(tgt_req), 64'h0);
        check_output("abort_tgt_sel", 64'(tgt_sel), 64'h0);
        check_output("abort_tgt_addr", 64'(tgt_addr), 64'h0);
        check_output("abort_valid", 64'(bus.resp_valid), 64'h0);
        check_output("abort_ready", 64'(bus.req_ready), 64'h1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        apply_stimulus(32'h005F_7C18, 1'b0, 64'h0, 8'h00, 0, 2, 64'hFEED_FACE_0000_0001, acc);
        check_output("post_rst_latency", 64'(last_resp_cyc - acc), 64'd3);
        check_output("post_rst_rdata", last_rdata, 64'hFEED_FACE_0000_0001);
        check_output("post_rst_err", 64'(last_err), 64'h0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
